// File: rtl/hopfield_network_tm.sv
// Time-multiplexed Hopfield core.
// A single MAC walks the N x N weight matrix, one synapse per cycle. It
// produces one synaptic current per neuron and applies the Hebbian update to
// each weight in the same pass.
// Optional feature: define HOPFIELD_WEIGHT_DECAY_EN so that, in a learning
// pass, a weight whose two neurons both stayed silent decays 1 LSB toward 0.
module hopfield_network_tm #(
    parameter int unsigned       N       = 7,
    parameter int unsigned       PAT_W   = 4,
    parameter logic signed [15:0] ETA    = 16'sd32,
    parameter logic signed [15:0] W_MAX  = 16'sd1024,
    parameter logic signed [15:0] W_MIN  = -16'sd1024,
    parameter logic signed [31:0] I_EXT  = 32'sd131072
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              learning_enable,
    input  logic [PAT_W-1:0]  pattern_input,
    input  logic [N-1:0]      spikes_in,
    output logic              busy,
    output logic              done,
    output logic [32*N-1:0]   currents_out
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [16:0] ETA_X   = $signed({ETA[15], ETA});
    localparam logic signed [16:0] W_MAX_X = $signed({W_MAX[15], W_MAX});
    localparam logic signed [16:0] W_MIN_X = $signed({W_MIN[15], W_MIN});

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [N-1:0]        spk_q, spk_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    logic                learn_q, learn_d;
    logic signed [31:0]  acc_q, acc_d;
    logic [IW-1:0]       i_q, i_d;
    logic [IW-1:0]       j_q, j_d;
    logic signed [15:0]  w_q [N][N];
    logic signed [15:0]  w_d [N][N];
    logic signed [31:0]  cur_q [N];
    logic signed [31:0]  cur_d [N];
    logic [32*N-1:0]     out_q, out_d;

    logic [N-1:0]        pat_ext;
    logic signed [15:0]  w_cur;
    logic                spk_i, spk_j, diag, last_j, last_i;
    logic signed [31:0]  contrib, acc_sum, cur_result;
    logic signed [16:0]  w_ext, w_upd;
    logic signed [15:0]  w_new;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_j && last_i) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
    end

    // Pattern zero-extended to N so neurons at or above PAT_W see no drive
    always_comb begin
        pat_ext            = '0;
        pat_ext[PAT_W-1:0] = pat_q;
    end

    // Current synapse: weight read, MAC contribution and row-end result
    always_comb begin
        w_cur      = w_q[i_q][j_q];
        spk_i      = spk_q[i_q];
        spk_j      = spk_q[j_q];
        diag       = (i_q == j_q);
        last_j     = (j_q == IW'(N - 1));
        last_i     = (i_q == IW'(N - 1));
        contrib    = (!diag && spk_j) ? {{8{w_cur[15]}}, w_cur, 8'h00} : 32'sd0;
        acc_sum    = acc_q + contrib;
        cur_result = acc_sum + ((learn_q && pat_ext[i_q]) ? I_EXT : 32'sd0);
    end

    // Hebbian update of the current weight, clamped to [W_MIN, W_MAX]
    always_comb begin
        w_ext = {w_cur[15], w_cur};
        w_upd = w_ext;
        if (spk_i && spk_j) begin
            w_upd = w_ext + ETA_X;
        end else if (spk_i ^ spk_j) begin
            w_upd = w_ext - ETA_X;
`ifdef HOPFIELD_WEIGHT_DECAY_EN
        end else if (w_ext > 17'sd0) begin
            w_upd = w_ext - 17'sd1;
        end else if (w_ext < 17'sd0) begin
            w_upd = w_ext + 17'sd1;
`endif
        end
        if (w_upd > W_MAX_X) begin
            w_new = W_MAX;
        end else if (w_upd < W_MIN_X) begin
            w_new = W_MIN;
        end else begin
            w_new = w_upd[15:0];
        end
    end

    // Datapath next state: snapshot on start, walk the matrix in RUN
    always_comb begin
        spk_d   = spk_q;
        pat_d   = pat_q;
        learn_d = learn_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        w_d     = w_q;
        cur_d   = cur_q;
        out_d   = out_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    spk_d   = spikes_in;
                    pat_d   = pattern_input;
                    learn_d = learning_enable;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            StRun: begin
                acc_d = acc_sum;
                if (learn_q && !diag) begin
                    w_d[i_q][j_q] = w_new;
                end
                if (last_j) begin
                    cur_d[i_q] = cur_result;
                    acc_d      = '0;
                    j_d        = '0;
                    i_d        = last_i ? '0 : i_q + 1'b1;
                    // Publish the whole shadow set at once, merging in the final row,
                    // so the new currents are visible during the DONE cycle.
                    if (last_i) begin
                        for (int k = 0; k < N; k++) begin
                            out_d[32*k +: 32] = (IW'(k) == i_q) ? cur_result : cur_q[k];
                        end
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spk_q   <= '0;
            pat_q   <= '0;
            learn_q <= 1'b0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            w_q     <= '{default: '0};
            cur_q   <= '{default: '0};
            out_q   <= '0;
        end else begin
            spk_q   <= spk_d;
            pat_q   <= pat_d;
            learn_q <= learn_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
            w_q     <= w_d;
            cur_q   <= cur_d;
            out_q   <= out_d;
        end
    end

    assign currents_out = out_q;

endmodule

// File: tb/tb_hopfield_network_tm.sv
// Self-checking bench for hopfield_network_tm (N=7, PAT_W=4).
// A behavioural model predicts each pass's currents and pushes them to a
// queue when the pass starts; they are popped and compared when done pulses.
module tb_hopfield_network_tm;

    localparam int N     = 7;
    localparam int PAT_W = 4;
    localparam int LIMIT = 300;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              learning_enable;
    logic [PAT_W-1:0]  pattern_input;
    logic [N-1:0]      spikes_in;
    logic              busy;
    logic              done;
    logic [32*N-1:0]   currents_out;

    int n_cmp = 0;
    int n_err = 0;

    int mw [N][N];
    logic [32*N-1:0] exp_q [$];

    always #5 clk = ~clk;

    hopfield_network_tm #(
        .N     (N),
        .PAT_W (PAT_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .learning_enable (learning_enable),
        .pattern_input   (pattern_input),
        .spikes_in       (spikes_in),
        .busy            (busy),
        .done            (done),
        .currents_out    (currents_out)
    );

    function automatic int clampw(input int v);
        if (v > 1024) return 1024;
        if (v < -1024) return -1024;
        return v;
    endfunction

    // Model one pass: currents from pre-update weights, then Hebbian update
    task automatic model_pass(input logic [N-1:0] spk, input logic [PAT_W-1:0] pat,
                              input logic learn);
        logic [32*N-1:0] ev;
        int acc;
        ev = '0;
        for (int i = 0; i < N; i++) begin
            acc = 0;
            for (int j = 0; j < N; j++) begin
                if (i != j && spk[j]) acc += mw[i][j] * 256;
            end
            if (learn && i < PAT_W && pat[i]) acc += 131072;
            ev[32*i +: 32] = acc;
        end
        exp_q.push_back(ev);
        if (learn) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (i != j) begin
                        if (spk[i] && spk[j]) mw[i][j] = clampw(mw[i][j] + 32);
                        else if (spk[i] || spk[j]) mw[i][j] = clampw(mw[i][j] - 32);
`ifdef HOPFIELD_WEIGHT_DECAY_EN
                        else if (mw[i][j] > 0) mw[i][j] = mw[i][j] - 1;
                        else if (mw[i][j] < 0) mw[i][j] = mw[i][j] + 1;
`endif
                    end
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) mw[i][j] = 0;
        exp_q.delete();
    endtask

    // Count negedges (cycles after the start edge) until done, bounded
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done !== 1'b1 && cyc < LIMIT);
        if (done !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done within %0d cycles, required done", LIMIT);
            cyc = -1;
        end
    endtask

    // Scoreboard consumer: pop the prediction and compare every neuron
    task automatic score_pass(input string name);
        logic [32*N-1:0] ev;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got done with empty scoreboard, required pending pass", name);
            return;
        end
        ev = exp_q.pop_front();
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (currents_out[32*k +: 32] !== ev[32*k +: 32]) begin
                n_err++;
                $display("FAIL %s current[%0d]: got %0d required %0d", name, k,
                         $signed(currents_out[32*k +: 32]), $signed(ev[32*k +: 32]));
            end
        end
    endtask

    task automatic begin_pass(input logic [N-1:0] spk, input logic [PAT_W-1:0] pat,
                              input logic learn);
        @(negedge clk);
        spikes_in       = spk;
        pattern_input   = pat;
        learning_enable = learn;
        start           = 1'b1;
        @(posedge clk);
        model_pass(spk, pat, learn);
        #1;
        start           = 1'b0;
        spikes_in       = $urandom();
        pattern_input   = $urandom();
        learning_enable = $urandom_range(0, 1);
    endtask

    task automatic run_pass(input string name, input logic [N-1:0] spk,
                            input logic [PAT_W-1:0] pat, input logic learn);
        int cyc;
        begin_pass(spk, pat, learn);
        wait_done(cyc);
        if (cyc >= 0) begin
            n_cmp++;
            if (cyc != N * N + 1) begin
                n_err++;
                $display("FAIL %s latency: got %0d required %0d", name, cyc, N * N + 1);
            end
            score_pass(name);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        learning_enable = 1'b0;
        pattern_input = '0;
        spikes_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || currents_out !== '0) begin
            n_err++;
            $display("FAIL reset_held: got busy=%b done=%b cur=%h required 0/0/0",
                     busy, done, currents_out);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || currents_out !== '0) begin
            n_err++;
            $display("FAIL reset_release: got busy=%b done=%b cur=%h required 0/0/0",
                     busy, done, currents_out);
        end
        run_pass("reset_recall", 7'h7F, 4'b0000, 1'b0);
    endtask

    task automatic test_pattern_drive();
        run_pass("pattern_drive", 7'b0000000, 4'b1011, 1'b1);
        n_cmp++;
        if ($signed(currents_out[31:0]) != 131072 || $signed(currents_out[95:64]) != 0 ||
            $signed(currents_out[127:96]) != 131072) begin
            n_err++;
            $display("FAIL pattern_const: got c0=%0d c2=%0d c3=%0d required 131072/0/131072",
                     $signed(currents_out[31:0]), $signed(currents_out[95:64]),
                     $signed(currents_out[127:96]));
        end
    endtask

    task automatic test_hebbian_recall();
        run_pass("hebb_learn", 7'b0000011, 4'b0000, 1'b1);
        run_pass("hebb_recall", 7'b0000001, 4'b0000, 1'b0);
        n_cmp++;
        if ($signed(currents_out[63:32]) != 8192 || $signed(currents_out[95:64]) != -8192 ||
            $signed(currents_out[31:0]) != 0) begin
            n_err++;
            $display("FAIL hebb_const: got c0=%0d c1=%0d c2=%0d required 0/8192/-8192",
                     $signed(currents_out[31:0]), $signed(currents_out[63:32]),
                     $signed(currents_out[95:64]));
        end
    endtask

    task automatic test_saturation();
        for (int p = 0; p < 40; p++) run_pass("sat_learn", 7'b0000011, 4'b0000, 1'b1);
        run_pass("sat_recall", 7'b0000001, 4'b0000, 1'b0);
        n_cmp++;
        if ($signed(currents_out[63:32]) != 262144 ||
            $signed(currents_out[95:64]) != -262144) begin
            n_err++;
            $display("FAIL sat_const: got c1=%0d c2=%0d required 262144/-262144",
                     $signed(currents_out[63:32]), $signed(currents_out[95:64]));
        end
        run_pass("sat_recall_all", 7'h7F, 4'b0000, 1'b0);
    endtask

`ifdef HOPFIELD_WEIGHT_DECAY_EN
    task automatic test_decay();
        for (int p = 0; p < 1024; p++) run_pass("decay_learn", 7'b0000000, 4'b0000, 1'b1);
        run_pass("decay_recall", 7'b0000001, 4'b0000, 1'b0);
        n_cmp++;
        if ($signed(currents_out[63:32]) != 0) begin
            n_err++;
            $display("FAIL decay_const: got c1=%0d required 0", $signed(currents_out[63:32]));
        end
    endtask
`endif

    task automatic test_busy_ignore();
        int cyc, n_done, first;
        begin_pass(7'b0110101, 4'b0101, 1'b1);
        n_done = 0;
        first = -1;
        for (cyc = 1; cyc <= 120; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_high: got %b required 1", busy);
                end
            end
            if (cyc == 10) start = 1'b1;
            if (cyc == 11) start = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (first < 0) begin
                    first = cyc;
                    score_pass("busy_ignore");
                end
            end
        end
        n_cmp++;
        if (n_done != 1 || first != N * N + 1) begin
            n_err++;
            $display("FAIL busy_ignore_done: got %0d dones first at %0d required 1 at %0d",
                     n_done, first, N * N + 1);
        end
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        logic [N-1:0] spk;
        spk = 7'b1011010;
        @(negedge clk);
        spikes_in       = spk;
        pattern_input   = 4'b1110;
        learning_enable = 1'b1;
        start           = 1'b1;
        @(posedge clk);
        model_pass(spk, 4'b1110, 1'b1);
        wait_done(c1);
        if (c1 < 0) return;
        n_cmp++;
        if (c1 != N * N + 1) begin
            n_err++;
            $display("FAIL b2b_first_latency: got %0d required %0d", c1, N * N + 1);
        end
        score_pass("b2b_first");
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle_gap: got busy=%b required 0", busy);
        end
        @(posedge clk);
        model_pass(spk, 4'b1110, 1'b1);
        #1;
        start = 1'b0;
        wait_done(c2);
        if (c2 < 0) return;
        n_cmp++;
        if (c2 + 1 != N * N + 2) begin
            n_err++;
            $display("FAIL b2b_interval: got %0d required %0d", c2 + 1, N * N + 2);
        end
        score_pass("b2b_second");
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            run_pass("rand_pass", N'($urandom()), PAT_W'($urandom()), 1'($urandom_range(0, 1)));
        end
        run_pass("rand_recall", 7'h7F, 4'b0000, 1'b0);
    endtask

    task automatic test_reset_mid_pass();
        begin_pass(7'h7F, 4'b1111, 1'b1);
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || currents_out !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got busy=%b done=%b cur=%h required 0/0/0",
                     busy, done, currents_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_pass("mid_reset_recall", 7'h7F, 4'b1111, 1'b0);
    endtask

    initial begin
        test_reset();
        test_pattern_drive();
        test_hebbian_recall();
        test_saturation();
`ifdef HOPFIELD_WEIGHT_DECAY_EN
        test_decay();
`endif
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid_pass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
